pow2_shift_sequencer: RTL and testbench
=======================================

# pow2_shift_sequencer

Multi-cycle controller that sequences a single one-bit arithmetic-right-shift stage to compute either `a >>> k` (floor) or signed `a / 2^k` (truncation toward zero) for a runtime shift amount `k`. It sits between a valid/ready producer and a valid/ready consumer in the arithmetic datapath. It trades latency for area: one shared 1-bit shifter, reused `k` times.

## Interface
- `N`, default 8: operand and result width in bits, N ≥ 2.
- `KW`, default 4: width of the shift-amount field. Any `k` value is legal; the effective shift is clamped to N.
- `clk` input, 1 bit: the single clock. All state updates on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `in_valid` input, 1 bit: request present.
- `in_ready` output, 1 bit: block can accept a request.
- `in_a` input, N bits: signed operand, two's complement.
- `in_k` input, KW bits: unsigned shift amount.
- `in_div` input, 1 bit: 0 = arithmetic shift (floor); 1 = signed divide (round toward zero).
- `out_valid` output, 1 bit: result present.
- `out_ready` input, 1 bit: consumer accepts the result.
- `out_data` output, N bits: signed result.

## Operation
- Request handshake: `in_valid & in_ready` at a rising edge. Result handshake: `out_valid & out_ready` at a rising edge.
- Effective shift amount: ke = min(in_k, N), captured at acceptance.
- Working register `acc` is N+1 bits, loaded with `in_a` sign-extended. Down-counter `cnt` is loaded with ke. Mode flag is captured from `in_div`.
- State machine (states IDLE, PREP, SHIFT, DONE):
  - IDLE: `in_ready`=1. On a request handshake, load `acc`, `cnt` and the mode flag, then go to PREP.
  - PREP: if div mode and `acc` is negative, `acc` ← `acc` + (2^ke − 1), computed in N+1 bits (no overflow is possible). Otherwise `acc` is unchanged. Next state is SHIFT if ke > 0, else DONE.
  - SHIFT: `acc` ← one-bit arithmetic right shift of `acc`; `cnt` ← `cnt` − 1. When `cnt` = 1, go to DONE.
  - DONE: `out_valid`=1, `out_data` = `acc[N-1:0]`. On a result handshake, go to IDLE.
- `in_ready` is asserted only in IDLE. `in_valid` in any other state is ignored, and the input values are not sampled.
- `out_data` holds stable throughout DONE regardless of `out_ready`.
- ke = N in shift mode: result is all sign bits. ke = N in div mode: result is 0 for every operand.
- Reset (any time, including mid-operation): go to IDLE, clear `acc` and `cnt`, and drop any in-flight operation silently.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0.
- Latency: with the request accepted at edge E0, `out_valid` rises after edge E0+1+ke. This is 1 cycle for ke=0 and N+1 cycles maximum.
- `in_ready` and `out_valid` are decoded from registered state only; there is no combinational path from any input to any output.
- No overlap between operations. The earliest next acceptance is the edge after the result handshake, so the minimum period is ke+3 cycles.
- A result handshake and a new `in_valid` in the same cycle: only the result is consumed. The new request waits for IDLE.

## Structure
- Shared package `pow2_shift_pkg` holds:
  - state enum `pow2_shift_state_t` (IDLE, PREP, SHIFT, DONE);
  - helper function for the ke clamp.
- Sub-module `arith_shift_right_by_1`, parameter W:
  - purely combinational;
  - implemented with concatenation only: result = top bit of the input, followed by input bits W−1 down to 1;
  - instantiated once with W = N+1.
- Top level contains the FSM, `cnt`, the bias adder and the output register.

## Test plan
- Shift mode, `in_a`=8'hF0, `in_k`=2 → `out_data`=8'hFC. `out_valid` rises 3 edges after acceptance.
- Same operand 8'hF9 (−7), `in_k`=1: shift mode → 8'hFC (−4); div mode → 8'hFD (−3). Also div mode with 8'h07 → 8'h03.
- `in_k`=0 in both modes, `in_a`=8'h85 → 8'h85, with 1-cycle latency.
- Clamp and extremes:
  - `in_k`=9, shift mode, `in_a`=8'h80 → 8'hFF;
  - `in_k`=9, div mode, `in_a`=8'h80 → 8'h00;
  - `in_k`=7, div mode, `in_a`=8'h80 → 8'hFF;
  - `in_k`=15, div mode, `in_a`=8'hFF → 8'h00.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE. `out_data` stays stable, `in_ready` stays 0, and a concurrent `in_valid` with a different operand is not captured.
- Assert `rst` during SHIFT with `in_k`=6. `out_valid`=0 and `in_ready`=1 immediately. The next request, 8'h40 with k=3 in shift mode, returns 8'h08.

Source files
------------

// File: rtl/pow2_shift_sequencer_pkg.sv
// rtl/pow2_shift_sequencer_pkg.sv - shared state enum and shift-amount clamp helper
package pow2_shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PREP  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } pow2_shift_state_t;

    // Shifting an N-bit value by N or more places saturates, so any larger
    // request behaves exactly like a shift by N.
    function automatic int unsigned clamp_ke(input int unsigned k, input int unsigned n);
        return (k > n) ? n : k;
    endfunction

endpackage

// File: rtl/pow2_shift_sequencer_if.sv
// rtl/pow2_shift_sequencer_if.sv - request/result handshake bundle
interface pow2_shift_sequencer_if #(
    parameter int N  = 8,
    parameter int KW = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in_a;
    logic [KW-1:0]  in_k;
    logic           in_div;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   out_data;

    // Producer/consumer side of the sequencer.
    modport master (
        output in_valid, in_a, in_k, in_div, out_ready,
        input  in_ready, out_valid, out_data
    );

    // The sequencer itself.
    modport slave (
        input  in_valid, in_a, in_k, in_div, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pow2_shift_sequencer_shr1.sv
// rtl/pow2_shift_sequencer_shr1.sv - combinational one-bit arithmetic right shift
module arith_shift_right_by_1 #(
    parameter int W = 9
) (
    input  logic [W-1:0] a_i,
    output logic [W-1:0] y_o
);
    // Replicate the sign bit into the vacated MSB.
    assign y_o = {a_i[W-1], a_i[W-1:1]};
endmodule

// File: rtl/pow2_shift_sequencer.sv
// rtl/pow2_shift_sequencer.sv - multi-cycle a>>>k / signed a/2^k sequencer
module pow2_shift_sequencer
    import pow2_shift_pkg::*;
#(
    parameter int N  = 8,
    parameter int KW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    pow2_shift_sequencer_if.slave bus
);
    localparam int W  = N + 1;
    localparam int CW = $clog2(N + 1);

    pow2_shift_state_t state_q;
    logic [W-1:0]      acc_q;
    logic [CW-1:0]     cnt_q;
    logic              div_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [N-1:0]      out_data_q;

    logic [CW-1:0]     ke_d;
    logic [W-1:0]      shr_d;
    logic [W-1:0]      bias_d;

    assign ke_d = CW'(clamp_ke(32'(bus.in_k), N));

    // In PREP cnt still holds ke, so this is 2^ke - 1; 1<<N fits in N+1 bits.
    assign bias_d = (W'(1) << cnt_q) - W'(1);

    arith_shift_right_by_1 #(.W(W)) u_shr (
        .a_i (acc_q),
        .y_o (shr_d)
    );

    // Control FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            div_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        acc_q      <= {bus.in_a[N-1], bus.in_a};
                        cnt_q      <= ke_d;
                        div_q      <= bus.in_div;
                        in_ready_q <= 1'b0;
                        state_q    <= PREP;
                    end
                end
                PREP: begin
                    // Biasing negatives turns the floor shift into truncation toward zero.
                    if (div_q && acc_q[W-1]) begin
                        acc_q <= acc_q + bias_d;
                    end
                    if (cnt_q != '0) begin
                        state_q <= SHIFT;
                    end else begin
                        // ke = 0 means bias is zero, so acc is already the result.
                        out_data_q  <= acc_q[N-1:0];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                SHIFT: begin
                    acc_q <= shr_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        out_data_q  <= shr_d[N-1:0];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_pow2_shift_sequencer.sv
// tb/tb_pow2_shift_sequencer.sv - directed self-checking bench for pow2_shift_sequencer
module tb_pow2_shift_sequencer;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    pow2_shift_sequencer_if #(.N(8), .KW(4)) bus ();

    pow2_shift_sequencer #(.N(8), .KW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a request and hold it until the acceptance edge.
    task automatic send_req(input logic [7:0] a, input logic [3:0] k, input logic d);
        int guard;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.in_a     = a;
        bus.in_k     = k;
        bus.in_div   = d;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Count edges after acceptance until out_valid, bounded.
    task automatic wait_result(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    // One full operation: data and latency (ke + 1) are both checked.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [3:0] k,
                          input logic d, input logic [7:0] exp, input int exp_lat);
        int lat;
        send_req(a, k, d);
        wait_result(lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, 32'(bus.out_data), 32'(exp));
        consume();
    endtask

    initial begin
        int lat;
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_k      = '0;
        bus.in_div    = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("shr_f0_k2",   8'hF0, 4'd2,  1'b0, 8'hFC, 3);
        run_op("shr_f9_k1",   8'hF9, 4'd1,  1'b0, 8'hFC, 2);
        run_op("div_f9_k1",   8'hF9, 4'd1,  1'b1, 8'hFD, 2);
        run_op("div_07_k1",   8'h07, 4'd1,  1'b1, 8'h03, 2);
        run_op("shr_85_k0",   8'h85, 4'd0,  1'b0, 8'h85, 1);
        run_op("div_85_k0",   8'h85, 4'd0,  1'b1, 8'h85, 1);
        run_op("shr_80_k9",   8'h80, 4'd9,  1'b0, 8'hFF, 9);
        run_op("div_80_k9",   8'h80, 4'd9,  1'b1, 8'h00, 9);
        run_op("div_80_k7",   8'h80, 4'd7,  1'b1, 8'hFF, 8);
        run_op("div_ff_k15",  8'hFF, 4'd15, 1'b1, 8'h00, 9);
        run_op("div_6c_k2",   8'h6C, 4'd2,  1'b1, 8'h1B, 3);

        // Backpressure: result held, no new request captured while in DONE.
        send_req(8'hF0, 4'd2, 1'b0);
        wait_result(lat);
        check("bp_lat", 32'(lat), 32'd3);
        bus.in_valid = 1'b1;
        bus.in_a     = 8'h11;
        bus.in_k     = 4'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_data", 32'(bus.out_data), 32'hFC);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        end
        // Result handshake with in_valid still high: only the result is consumed.
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        check("bp_no_capture", 32'(bus.in_ready), 32'd1);

        // Reset in the middle of SHIFT drops the operation.
        send_req(8'h7F, 4'd6, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        run_op("post_rst_40_k3", 8'h40, 4'd3, 1'b0, 8'h08, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
